// File: rtl/ac97_link_rx.sv
// AC-link codec-side frame receiver: slot 0 tag, slot 1/2 command, slot 3/4 PCM.
// Optional `AC97_LINK_RX_STATS_EN adds frame_cnt/err_cnt statistics ports.
module ac97_link_rx #(
    parameter int PCM_WIDTH   = 18,
    parameter bit STRICT_SYNC = 1'b1
) (
    input  logic                 bit_clk,
    input  logic                 reset,
    input  logic                 sync,
    input  logic                 sdata_out,
    output logic [15:0]          tag,
    output logic                 cmd_valid,
    output logic                 cmd_rw,
    output logic [6:0]           cmd_addr,
    output logic [15:0]          cmd_data,
    output logic                 pcm_valid,
    output logic [PCM_WIDTH-1:0] pcm_left,
    output logic [PCM_WIDTH-1:0] pcm_right,
    output logic                 frame_err,
`ifdef AC97_LINK_RX_STATS_EN
    output logic [15:0]          frame_cnt,
    output logic [15:0]          err_cnt,
`endif
    output logic                 locked
);

    typedef enum logic [1:0] {HUNT, TAG, SLOTS} state_t;

    state_t               state_q;
    logic                 sync_q;
    logic [7:0]           bit_cnt_q;
    logic [19:0]          sr_q;
    logic [15:0]          tag_q;
    logic [7:0]           s1_q;
    logic [PCM_WIDTH-1:0] s3_q;
    logic                 cmd_valid_q, cmd_rw_q, pcm_valid_q;
    logic [6:0]           cmd_addr_q;
    logic [15:0]          cmd_data_q;
    logic [PCM_WIDTH-1:0] pcm_left_q, pcm_right_q;
    logic                 frame_err_q, locked_q;
`ifdef AC97_LINK_RX_STATS_EN
    logic [15:0]          frame_cnt_q, err_cnt_q;
`endif

    logic        rise;
    logic [19:0] sr_d;
    logic [7:0]  cnt_d;
    logic        err_d, cmd_d, pcm_d, done_d;

    assign rise  = sync & ~sync_q;
    assign sr_d  = {sr_q[18:0], sdata_out};
    assign cnt_d = bit_cnt_q + 8'd1;

    // bit_cnt 0 while in SLOTS means the wrapped slot expecting the next frame's sync rise
    always_comb begin
        err_d = 1'b0;
        case (state_q)
            TAG:     err_d = STRICT_SYNC && !sync;
            SLOTS:   err_d = (bit_cnt_q == 8'd0) ? !rise
                           : (rise || (STRICT_SYNC && sync));
            default: err_d = 1'b0;
        endcase
    end

    assign cmd_d  = (state_q == SLOTS) && (bit_cnt_q == 8'd55) && !err_d
                    && tag_q[15] && tag_q[14] && tag_q[13];
    assign pcm_d  = (state_q == SLOTS) && (bit_cnt_q == 8'd95) && !err_d
                    && tag_q[15] && tag_q[12] && tag_q[11];
    assign done_d = (state_q == SLOTS) && (bit_cnt_q == 8'd255) && !err_d;

    always_ff @(posedge bit_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            sync_q      <= 1'b0;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            tag_q       <= '0;
            s1_q        <= '0;
            s3_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_rw_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            pcm_valid_q <= 1'b0;
            pcm_left_q  <= '0;
            pcm_right_q <= '0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
`ifdef AC97_LINK_RX_STATS_EN
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
`endif
        end else begin
            sync_q      <= sync;
            frame_err_q <= err_d;
            cmd_valid_q <= cmd_d;
            pcm_valid_q <= pcm_d;
            case (state_q)
                HUNT: begin
                    if (rise) begin
                        sr_q      <= sr_d;
                        bit_cnt_q <= 8'd1;
                        state_q   <= TAG;
                    end
                end
                TAG: begin
                    if (err_d) begin
                        locked_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= HUNT;
                    end else begin
                        sr_q      <= sr_d;
                        bit_cnt_q <= cnt_d;
                        if (bit_cnt_q == 8'd15) begin
                            tag_q    <= sr_d[15:0];
                            locked_q <= 1'b1;
                            state_q  <= SLOTS;
                        end
                    end
                end
                SLOTS: begin
                    if (rise) begin
                        sr_q      <= sr_d;
                        bit_cnt_q <= 8'd1;
                        state_q   <= TAG;
                        if (bit_cnt_q != 8'd0) locked_q <= 1'b0;
                    end else if (err_d) begin
                        locked_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= HUNT;
                    end else begin
                        sr_q      <= sr_d;
                        bit_cnt_q <= cnt_d;
                        if (bit_cnt_q == 8'd35) s1_q <= sr_d[19:12];
                        if (bit_cnt_q == 8'd75) s3_q <= sr_d[19 -: PCM_WIDTH];
                    end
                end
                default: state_q <= HUNT;
            endcase
            if (cmd_d) begin
                cmd_rw_q   <= s1_q[7];
                cmd_addr_q <= s1_q[6:0];
                cmd_data_q <= sr_d[19:4];
            end
            if (pcm_d) begin
                pcm_left_q  <= s3_q;
                pcm_right_q <= sr_d[19 -: PCM_WIDTH];
            end
`ifdef AC97_LINK_RX_STATS_EN
            if (done_d && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (err_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
`endif
        end
    end

    assign tag       = tag_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_rw    = cmd_rw_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign pcm_valid = pcm_valid_q;
    assign pcm_left  = pcm_left_q;
    assign pcm_right = pcm_right_q;
    assign frame_err = frame_err_q;
    assign locked    = locked_q;
`ifdef AC97_LINK_RX_STATS_EN
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    logic unused_done;
    assign unused_done = done_d;
`endif

endmodule
